// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forward-mux selects and the
// stall/flush reason, which is kept as a named signal for debug visibility.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_CACHE,
    HZ_DATA,
    HZ_REDIRECT
  } hz_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Pending-write scoreboard for long-latency ops that complete out of band,
// plus the outstanding-op count that limits how many can be in flight.
module hz_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int MAX_LONG = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            issue,
  input  logic [AW-1:0]   issue_rd,
  input  logic            done,
  input  logic [AW-1:0]   done_rd,
  output logic [NREG-1:0] sb,
  output logic            full
);

  localparam int LW = $clog2(MAX_LONG + 1);

  logic [NREG-1:0] sb_nxt;
  logic [LW-1:0]   lcnt;
  logic [LW-1:0]   lcnt_nxt;

  // Set is applied after clear so a newer issue to the same register wins.
  always_comb begin
    sb_nxt = sb;
    if (done) sb_nxt[done_rd] = 1'b0;
    if (issue) sb_nxt[issue_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_comb begin
    lcnt_nxt = lcnt;
    case ({issue, done})
      2'b10: if (lcnt != LW'(MAX_LONG)) lcnt_nxt = lcnt + LW'(1);
      2'b01: if (lcnt != '0) lcnt_nxt = lcnt - LW'(1);
      default: lcnt_nxt = lcnt;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sb   <= '0;
      lcnt <= '0;
    end else begin
      sb   <= sb_nxt;
      lcnt <= lcnt_nxt;
    end
  end

  assign full = (lcnt == LW'(MAX_LONG));

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: prioritised stall/flush generation, E/D-stage
// forwarding selects, scoreboard for long-latency writers and perf counters.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int AW          = $clog2(NREG),
  parameter int XLEN        = 32,
  parameter int MAX_LONG    = 4,
  parameter bit BRANCH_IN_D = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    RdD,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [AW-1:0]    RdE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReadE,
  input  logic             MemWriteE,
  input  logic             MemReadD,
  input  logic             BranchD,
  input  logic [XLEN-1:0]  StoreAddrE,
  input  logic [XLEN-1:0]  LoadAddrD,
  input  logic [2:0]       PCSrcE,
  input  logic             LongOpD,
  input  logic             LongIssueE,
  input  logic             LongDone,
  input  logic [AW-1:0]    LongDoneRd,
  input  logic             CacheBusy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       ForwardAD,
  output logic [1:0]       ForwardBD,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  logic [NREG-1:0] sb;
  logic            full;
  logic            dh;
  hz_t             reason;

  // A frozen pipe does not advance, so an issue during CacheBusy is not real.
  hz_scoreboard #(.NREG(NREG), .AW(AW), .MAX_LONG(MAX_LONG)) u_sb (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .issue    (LongIssueE && !CacheBusy),
    .issue_rd (RdE),
    .done     (LongDone),
    .done_rd  (LongDoneRd),
    .sb       (sb),
    .full     (full)
  );

  always_comb begin
    dh = 1'b0;
    if (MemReadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D)) dh = 1'b1;
    if (MemWriteE && MemReadD && StoreAddrE == LoadAddrD) dh = 1'b1;
    if (BRANCH_IN_D && BranchD && RegWriteE && RdE != '0 &&
        (RdE == Rs1D || RdE == Rs2D)) dh = 1'b1;
    if (sb[Rs1D] || sb[Rs2D] || sb[RdD]) dh = 1'b1;
    if (LongOpD && full) dh = 1'b1;
  end

  always_comb begin
    reason = HZ_NONE;
    if (CacheBusy) reason = HZ_CACHE;
    else if (dh) reason = HZ_DATA;
    else if (PCSrcE != 3'b000) reason = HZ_REDIRECT;
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    case (reason)
      HZ_CACHE: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end
      HZ_DATA: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      HZ_REDIRECT: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic fwd_t fwd_sel(input logic [AW-1:0] src, input logic we_m,
                                   input logic [AW-1:0] rd_m, input logic we_w,
                                   input logic [AW-1:0] rd_w);
    if (we_m && rd_m != '0 && rd_m == src) return FWD_M;
    if (we_w && rd_w != '0 && rd_w == src) return FWD_W;
    return FWD_RF;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardAD = fwd_sel(Rs1D, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBD = fwd_sel(Rs2D, RegWriteM, RdM, RegWriteW, RdW);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && StallCycles != '1) StallCycles <= StallCycles + CNT_W'(1);
      if (FlushD && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Scoreboard bench for hazard_ctrl_sb: directed stimulus pushes hand-computed
// expectations each cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl_sb;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
  logic        RegWriteE, RegWriteM, RegWriteW, MemReadE, MemWriteE, MemReadD, BranchD;
  logic [31:0] StoreAddrE, LoadAddrD;
  logic [2:0]  PCSrcE;
  logic        LongOpD, LongIssueE, LongDone, CacheBusy;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE, ForwardAD, ForwardBD;
  logic [3:0]  StallCycles, FlushCount;

  hazard_ctrl_sb #(.NREG(32), .XLEN(32), .MAX_LONG(4), .BRANCH_IN_D(1'b1), .CNT_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .MemReadD(MemReadD), .BranchD(BranchD),
    .StoreAddrE(StoreAddrE), .LoadAddrD(LoadAddrD), .PCSrcE(PCSrcE),
    .LongOpD(LongOpD), .LongIssueE(LongIssueE), .LongDone(LongDone),
    .LongDoneRd(LongDoneRd), .CacheBusy(CacheBusy),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] sc = 4'd0;
  logic [3:0] fc = 4'd0;

  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      e   = q.pop_front();
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE,
             ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallCycles, FlushCount};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got stall=%b flush=%b fwd=%b sc=%0d fc=%0d, want stall=%b flush=%b fwd=%b sc=%0d fc=%0d",
                 e.nm, act[21:18], act[17:16], act[15:8], act[7:4], act[3:0],
                 e.v[21:18], e.v[17:16], e.v[15:8], e.v[7:4], e.v[3:0]);
      end
    end
  end

  task automatic clr();
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemReadE, MemWriteE, MemReadD, BranchD} = '0;
    StoreAddrE = '0; LoadAddrD = '0; PCSrcE = '0;
    {LongOpD, LongIssueE, LongDone, CacheBusy} = '0;
  endtask

  // Expected counters reflect stalls/flushes of earlier cycles only.
  task automatic step(input string nm, input logic [3:0] st, input logic [1:0] fl,
                      input logic [7:0] fw);
    exp_t e;
    e.nm = nm;
    e.v  = {st, fl, fw, sc, fc};
    q.push_back(e);
    @(posedge CLK);
    if (RESET_N) begin
      if (st[3] && sc != 4'hF) sc = sc + 4'd1;
      if (fl[1] && fc != 4'hF) fc = fc + 4'd1;
    end
    #1;
  endtask

  task automatic go_reset();
    RESET_N = 1'b0;
    clr();
    sc = 4'd0;
    fc = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    clr();
    @(posedge CLK); #1;
    step("reset", 4'b0000, 2'b00, 8'h00);
    RESET_N = 1'b1;
    step("idle", 4'b0000, 2'b00, 8'h00);

    // load-use then M-stage forward
    MemReadE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5;
    step("load_use", 4'b1100, 2'b01, 8'h00);
    clr(); RegWriteM = 1; RdM = 5; Rs1E = 5;
    step("load_fwd_m", 4'b0000, 2'b00, 8'b10_00_00_00);

    // long op to x7, consumer waits until the cycle after LongDone
    clr(); LongIssueE = 1; RdE = 7;
    step("long_issue", 4'b0000, 2'b00, 8'h00);
    clr(); Rs2D = 7;
    for (int i = 1; i <= 6; i++) begin
      LongDone = (i == 6); LongDoneRd = (i == 6) ? 5'd7 : 5'd0;
      step("long_wait", 4'b1100, 2'b01, 8'h00);
    end
    clr(); Rs2D = 7; RegWriteW = 1; RdW = 7;
    step("long_release", 4'b0000, 2'b00, 8'b00_00_00_01);

    // fill all long slots, then LongOpD must stall
    for (int i = 1; i <= 4; i++) begin
      clr(); LongIssueE = 1; RdE = 5'(i);
      step("long_fill", 4'b0000, 2'b00, 8'h00);
    end
    clr(); LongOpD = 1;
    step("long_full", 4'b1100, 2'b01, 8'h00);
    LongIssueE = 1; RdE = 8; LongDone = 1; LongDoneRd = 1;
    step("long_full_issue_done", 4'b1100, 2'b01, 8'h00);
    clr(); LongOpD = 1;
    step("long_full_held", 4'b1100, 2'b01, 8'h00);

    // reset discards all pending entries
    go_reset();
    step("reset2", 4'b0000, 2'b00, 8'h00);
    RESET_N = 1'b1;
    LongOpD = 1; Rs1D = 2; RdD = 8;
    step("sb_cleared", 4'b0000, 2'b00, 8'h00);

    // done with nothing outstanding must not wrap the counter
    clr(); LongDone = 1; LongDoneRd = 3;
    step("underflow", 4'b0000, 2'b00, 8'h00);
    for (int i = 11; i <= 14; i++) begin
      clr(); LongIssueE = 1; RdE = 5'(i);
      step("refill", 4'b0000, 2'b00, 8'h00);
    end
    clr(); LongOpD = 1;
    step("refill_full", 4'b1100, 2'b01, 8'h00);
    go_reset();
    step("reset3", 4'b0000, 2'b00, 8'h00);
    RESET_N = 1'b1;

    // store-to-load address match
    clr(); MemWriteE = 1; MemReadD = 1; StoreAddrE = 32'h1000; LoadAddrD = 32'h1000;
    step("st_ld_hit", 4'b1100, 2'b01, 8'h00);
    LoadAddrD = 32'h1004;
    step("st_ld_miss", 4'b0000, 2'b00, 8'h00);

    // D-stage branch on E-stage ALU result
    clr(); BranchD = 1; RegWriteE = 1; RdE = 9; Rs2D = 9;
    step("branch_dep", 4'b1100, 2'b01, 8'h00);
    RdE = 0; Rs2D = 0;
    step("branch_x0", 4'b0000, 2'b00, 8'h00);

    // redirect
    clr(); PCSrcE = 3'b100;
    step("redirect", 4'b0000, 2'b11, 8'h00);

    // cache freeze dominates data hazard and redirect
    clr(); CacheBusy = 1; PCSrcE = 3'b001; MemReadE = 1; RdE = 4; Rs1D = 4;
    step("cache_prio", 4'b1111, 2'b00, 8'h00);
    clr(); PCSrcE = 3'b001;
    step("cache_drop", 4'b0000, 2'b11, 8'h00);
    clr();
    step("flush_count", 4'b0000, 2'b00, 8'h00);

    // an issue under freeze must not mark the scoreboard
    clr(); CacheBusy = 1; LongIssueE = 1; RdE = 10;
    step("frozen_issue", 4'b1111, 2'b00, 8'h00);
    clr(); Rs1D = 10;
    step("frozen_issue_chk", 4'b0000, 2'b00, 8'h00);

    // forwarding priority M over W, x0 guard
    clr(); RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1D = 3; Rs1E = 3;
    step("fwd_m", 4'b0000, 2'b00, 8'b10_00_10_00);
    RdM = 0;
    step("fwd_w", 4'b0000, 2'b00, 8'b01_00_01_00);
    RdM = 3; RegWriteM = 0; Rs2E = 3; Rs2D = 3;
    step("fwd_w_all", 4'b0000, 2'b00, 8'b01_01_01_01);

    // saturation, then reset mid-stall
    clr(); LongIssueE = 1; RdE = 7;
    step("sat_issue", 4'b0000, 2'b00, 8'h00);
    clr(); CacheBusy = 1;
    for (int i = 0; i < 20; i++) step("stall_sat", 4'b1111, 2'b00, 8'h00);
    go_reset(); CacheBusy = 1;
    step("reset_mid_stall", 4'b1111, 2'b00, 8'h00);
    CacheBusy = 0; Rs2D = 7;
    step("reset_mid_idle", 4'b0000, 2'b00, 8'h00);
    RESET_N = 1'b1;
    step("post_reset_sb", 4'b0000, 2'b00, 8'h00);

    @(negedge CLK); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_sb.md
# hazard_ctrl_sb

Parametrised hazard controller for the 5-stage pipelined, cached RISC-V core. It adds a register scoreboard for long-latency writers (multicycle mul/div, D-cache miss refills) that complete out of band. It adds a whole-pipe freeze driven by cache busy, per-stage stall/flush outputs, saturating performance counters, and configurable branch-resolution forwarding. It sits beside the datapath and drives the F/D/E/M pipeline-register enables and flushes plus the E- and D-stage forwarding muxes.

## Interface
- NREG, 32, architectural register count; AW = $clog2(NREG)
- XLEN, 32, address width for the store/load compare
- MAX_LONG, 4, maximum outstanding long-latency ops
- BRANCH_IN_D, 1, 1 = branches compare in D, so any E-stage writer feeding a D branch stalls
- CNT_W, 32, performance counter width
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW  in  AW each  register indices per stage
- RegWriteE, RegWriteM, RegWriteW, MemReadE, MemWriteE, MemReadD, BranchD  in  1 each  stage control
- StoreAddrE, LoadAddrD  in  XLEN each  computed addresses
- PCSrcE  in  3  nonzero = redirect taken in E
- LongOpD  in  1  instruction in D is long-latency
- LongIssueE  in  1  long op leaves E this cycle (not frozen)
- LongDone  in  1  long op writes back
- LongDoneRd  in  AW  its destination
- CacheBusy  in  1  I- or D-cache miss in progress
- StallF, StallD, StallE, StallM  out  1 each  hold stage register
- FlushD, FlushE  out  1 each  bubble stage register
- ForwardAE, ForwardBE, ForwardAD, ForwardBD  out  2 each  00 regfile, 10 M, 01 W
- StallCycles, FlushCount  out  CNT_W each  saturating counters

## Operation
- Scoreboard: NREG-bit pending vector `sb`, and an outstanding counter `lcnt` (0..MAX_LONG).
  - On LongIssueE && RdE!=0 && !CacheBusy, set sb[RdE].
  - On LongDone, clear sb[LongDoneRd].
  - Same register set and cleared in one cycle: set wins (the newer issue owns it).
  - `lcnt` increments on issue and decrements on done; both in one cycle leaves it unchanged.
  - Bit 0 is never set.
- The data-hazard term `dh` is the OR of:
  - load-use: MemReadE && RdE!=0 && RdE∈{Rs1D,Rs2D};
  - store-to-load: MemWriteE && MemReadD && StoreAddrE==LoadAddrD;
  - branch: BRANCH_IN_D && BranchD && RegWriteE && RdE!=0 && RdE∈{Rs1D,Rs2D};
  - scoreboard RAW/WAW: sb[Rs1D] | sb[Rs2D] | sb[RdD];
  - long full: LongOpD && lcnt==MAX_LONG.
- Priority, highest first:
  - CacheBusy: StallF/D/E/M=1, FlushD=FlushE=0.
  - Else dh: StallF=StallD=1, FlushE=1, FlushD=0.
  - Else PCSrcE!=0: FlushD=FlushE=1.
  - Else all outputs 0.
- Forwarding, for each of Rs1E, Rs2E, Rs1D, Rs2D:
  - 10 if RegWriteM && RdM!=0 && RdM==src;
  - else 01 if RegWriteW && RdW!=0 && RdW==src;
  - else 00.
  - Forwarding is independent of stalls.
- Counters:
  - StallCycles increments on any cycle with StallF=1.
  - FlushCount increments on any cycle with FlushD=1.
  - Both saturate at all-ones.
- Underflow: LongDone with lcnt==0 keeps lcnt at 0.

## Timing
- All stall, flush and forward outputs are combinational from inputs, `sb` and `lcnt`; zero-cycle latency.
- `sb`, `lcnt` and the counters update on the CLK rising edge.
- Reset (asynchronous assert, synchronous-safe deassert) clears `sb`, `lcnt`, StallCycles and FlushCount. With inputs at 0, every output is 0 during and after reset.
- A long op issued in cycle t is visible to D in cycle t+1.
- LongDone in cycle t releases the stall in cycle t+1; the W-stage forward covers the write-back cycle.
- Reset mid-operation discards all pending entries. The datapath flushes concurrently, so no entry is lost.

## Structure
- Package `hazard_pkg`: forward-select enum (FWD_RF, FWD_W, FWD_M) and the priority-reason enum (HZ_NONE, HZ_CACHE, HZ_DATA, HZ_REDIRECT), used for debug.
- Sub-module `hz_scoreboard`: owns `sb`, `lcnt`, set/clear arbitration and the full flag.
- Top: the combinational priority block, the four forward comparators and the counters.

## Test plan
- Load x5 in E, Rs1D=5 → StallF=StallD=FlushE=1 for one cycle; next cycle ForwardAE=10.
- LongIssueE with RdE=7, then Rs2D=7 for 6 cycles; LongDone rd=7 in cycle 6 → stall held for cycles 1–6, released in cycle 7.
- Four long ops outstanding, LongOpD=1 → stall. Issue and done in the same cycle → `lcnt` stays 4 and the stall is held.
- CacheBusy=1 together with PCSrcE=3'b001 → all four stalls=1, FlushD=0. After CacheBusy drops → FlushD=FlushE=1 and FlushCount=1.
- RegWriteM RdM=3 and RegWriteW RdW=3, Rs1D=Rs1E=3 → ForwardAD=ForwardAE=10. With RdM=0 → 01.
- StallCycles preloaded at all-ones, then stall → stays all-ones. Assert RESET_N=0 mid-stall → `sb`, `lcnt` and the counters all read 0 immediately.
